// File: rtl/ej32_pkg.sv
// Shared eJ32 types: memory arbiter FSM states, read-return owner tags and default widths.
package ej32_pkg;

  typedef enum logic [1:0] {NORM, LOCK, DRAIN} arb_st_t;
  typedef enum logic [1:0] {RD_NONE, RD_CORE, RD_HOST} rd_own_t;

  localparam int ARB_AW = 17;
  localparam int DATA_W = 8;

endpackage

// File: rtl/ej32_mem_arb.sv
// Shares the byte-wide RAM port between the eJ32 core (priority) and the host port, with a
// bounded-wait host slot and a host_lock bulk mode. Optional stall counter: EJ32_ARB_STAT_EN.
module ej32_mem_arb
  import ej32_pkg::*;
#(
  parameter int AW       = ARB_AW,
  parameter int MAX_WAIT = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [AW-1:0]     core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic              core_stall,
  output logic [DATA_W-1:0] core_rdata,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [AW-1:0]     host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  input  logic              host_lock,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  output logic              mem_cs,
  output logic              mem_we,
  output logic [AW-1:0]     mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef EJ32_ARB_STAT_EN
  ,
  output logic [31:0]       stall_cnt
`endif
);

  localparam int WCW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);

  arb_st_t           state, state_nx;
  rd_own_t           rd_owner, rd_owner_nx;
  logic [WCW-1:0]    wait_cnt;
  logic [DATA_W-1:0] core_rdata_p1;
  logic              host_own, core_own;

  // Per-cycle owner decision and next-state logic
  always_comb begin
    state_nx = state;
    host_own = 1'b0;
    core_own = 1'b0;
    case (state)
      NORM: begin
        if (host_lock) state_nx = LOCK;
        host_own = host_lock | (host_req & (~core_req | (wait_cnt == WCW'(MAX_WAIT))));
        core_own = ~host_own;
      end
      LOCK: begin
        if (!host_lock) state_nx = DRAIN;
        host_own = 1'b1;
      end
      DRAIN:   state_nx = NORM;
      default: state_nx = NORM;
    endcase
  end

  // Reset forces the port idle and the core stalled, independent of the FSM.
  always_comb begin
    host_gnt   = rst_n & host_own & host_req;
    core_stall = ~rst_n | (core_req & ~core_own);
    mem_cs     = rst_n & (host_own ? host_req : (core_own & core_req));
    mem_we     = host_own ? host_we    : core_we;
    mem_addr   = host_own ? host_addr  : core_addr;
    mem_wdata  = host_own ? host_wdata : core_wdata;
  end

  always_comb begin
    rd_owner_nx = RD_NONE;
    if (host_gnt && !host_we)
      rd_owner_nx = RD_HOST;
    else if (core_own && core_req && !core_we)
      rd_owner_nx = RD_CORE;
  end

  // ---- registered control ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= NORM;
      rd_owner <= RD_NONE;
      wait_cnt <= '0;
    end else begin
      state    <= state_nx;
      rd_owner <= rd_owner_nx;
      if (state != LOCK) begin
        if (!host_req || host_gnt)
          wait_cnt <= '0;
        else if (wait_cnt != WCW'(MAX_WAIT))
          wait_cnt <= wait_cnt + WCW'(1);
      end
    end
  end

  // ---- read return stage: RAM data arrives one cycle after the grant ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      core_rdata_p1 <= '0;
    else if (rd_owner == RD_CORE)
      core_rdata_p1 <= mem_rdata;
  end

  // Bypass the holding register in the return cycle so the byte is usable right away.
  assign core_rdata  = (rd_owner == RD_CORE) ? mem_rdata : core_rdata_p1;
  assign host_rvalid = (rd_owner == RD_HOST);
  assign host_rdata  = mem_rdata;

`ifdef EJ32_ARB_STAT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_cnt <= '0;
    else if (core_req && core_stall)
      stall_cnt <= stall_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_ej32_mem_arb.sv
// Directed bench for ej32_mem_arb: vector table for arbitration cases plus hand-written
// sequences for fairness, lock/drain and reset during an outstanding read.
module tb_ej32_mem_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        core_req, core_we, core_stall;
  logic [16:0] core_addr;
  logic [7:0]  core_wdata, core_rdata;
  logic        host_req, host_we, host_lock, host_gnt, host_rvalid;
  logic [16:0] host_addr;
  logic [7:0]  host_wdata, host_rdata;
  logic        mem_cs, mem_we;
  logic [16:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;
`ifdef EJ32_ARB_STAT_EN
  logic [31:0] stall_cnt;
`endif

  ej32_mem_arb #(.AW(17), .MAX_WAIT(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_stall(core_stall), .core_rdata(core_rdata),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_lock(host_lock), .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
`ifdef EJ32_ARB_STAT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Synchronous RAM, one-cycle read latency
  logic [7:0] ram [0:131071];
  always @(posedge clk) begin
    if (mem_cs) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
    end
  end

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic drive(input logic creq, input logic cwe, input logic [16:0] caddr,
                       input logic [7:0] cwd, input logic hreq, input logic hwe,
                       input logic [16:0] haddr, input logic [7:0] hwd, input logic hlock);
    core_req = creq; core_we = cwe; core_addr = caddr; core_wdata = cwd;
    host_req = hreq; host_we = hwe; host_addr = haddr; host_wdata = hwd; host_lock = hlock;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 17'h0, 8'h0, 1'b0, 1'b0, 17'h0, 8'h0, 1'b0);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  typedef struct packed {
    logic        creq, cwe;
    logic [16:0] caddr;
    logic [7:0]  cwd;
    logic        hreq, hwe;
    logic [16:0] haddr;
    logic [7:0]  hwd;
    logic        hlock;
    logic        e_stall, e_gnt, e_cs, e_we;
    logic [16:0] e_addr;
    logic        e_rvalid;
    logic [7:0]  e_hrd, e_crd;
  } vec_t;

  vec_t vecs [9];

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int gnt_at;

    for (int a = 0; a < 131072; a++) ram[a] = 8'h00;
    ram[17'h1000] = 8'h5A;
    ram[17'h1400] = 8'h33;
    mem_rdata = 8'h00;

    // fields: creq cwe caddr cwd | hreq hwe haddr hwd hlock | stall gnt cs we addr | rvalid hrd crd
    vecs[0] = '{1'b1,1'b0,17'h1000,8'h00, 1'b0,1'b0,17'h0000,8'h00,1'b0, 1'b0,1'b0,1'b1,1'b0,17'h1000, 1'b0,8'h00,8'h00};
    vecs[1] = '{1'b0,1'b0,17'h0000,8'h00, 1'b1,1'b0,17'h1400,8'h00,1'b0, 1'b0,1'b1,1'b1,1'b0,17'h1400, 1'b0,8'h00,8'h5A};
    vecs[2] = '{1'b1,1'b1,17'h0200,8'hA5, 1'b1,1'b0,17'h1400,8'h00,1'b0, 1'b0,1'b0,1'b1,1'b1,17'h0200, 1'b1,8'h33,8'h5A};
    vecs[3] = '{1'b1,1'b0,17'h0200,8'h00, 1'b0,1'b0,17'h0000,8'h00,1'b0, 1'b0,1'b0,1'b1,1'b0,17'h0200, 1'b0,8'h00,8'h5A};
    vecs[4] = '{1'b1,1'b0,17'h0100,8'h00, 1'b1,1'b1,17'h0300,8'hC3,1'b1, 1'b1,1'b1,1'b1,1'b1,17'h0300, 1'b0,8'h00,8'hA5};
    vecs[5] = '{1'b1,1'b0,17'h0100,8'h00, 1'b0,1'b0,17'h0300,8'h00,1'b1, 1'b1,1'b0,1'b0,1'b0,17'h0000, 1'b0,8'h00,8'hA5};
    vecs[6] = '{1'b1,1'b0,17'h0100,8'h00, 1'b1,1'b1,17'h0301,8'h7E,1'b0, 1'b1,1'b1,1'b1,1'b1,17'h0301, 1'b0,8'h00,8'hA5};
    vecs[7] = '{1'b1,1'b0,17'h0100,8'h00, 1'b1,1'b0,17'h1400,8'h00,1'b0, 1'b1,1'b0,1'b0,1'b0,17'h0000, 1'b0,8'h00,8'hA5};
    vecs[8] = '{1'b1,1'b0,17'h0300,8'h00, 1'b1,1'b0,17'h1400,8'h00,1'b0, 1'b0,1'b0,1'b1,1'b0,17'h0300, 1'b0,8'h00,8'hA5};

    // Reset with both sides requesting: port must stay quiet
    rst_n = 1'b0;
    drive(1'b1, 1'b0, 17'h1000, 8'h00, 1'b1, 1'b0, 17'h1400, 8'h00, 1'b0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (c == 2) begin
        chk("rst_mem_cs", mem_cs, 0);
        chk("rst_core_stall", core_stall, 1);
        chk("rst_host_gnt", host_gnt, 0);
        chk("rst_core_rdata", core_rdata, 0);
        chk("rst_host_rvalid", host_rvalid, 0);
      end
      next_cycle();
    end
    rst_n = 1'b1;
    idle();
    @(negedge clk);
    chk("post_rst_core_stall", core_stall, 0);
    chk("post_rst_mem_cs", mem_cs, 0);
    next_cycle();

    for (int i = 0; i < 9; i++) begin
      drive(vecs[i].creq, vecs[i].cwe, vecs[i].caddr, vecs[i].cwd,
            vecs[i].hreq, vecs[i].hwe, vecs[i].haddr, vecs[i].hwd, vecs[i].hlock);
      @(negedge clk);
      chk($sformatf("v%0d_core_stall", i), core_stall, vecs[i].e_stall);
      chk($sformatf("v%0d_host_gnt", i), host_gnt, vecs[i].e_gnt);
      chk($sformatf("v%0d_mem_cs", i), mem_cs, vecs[i].e_cs);
      if (vecs[i].e_cs) begin
        chk($sformatf("v%0d_mem_we", i), mem_we, vecs[i].e_we);
        chk($sformatf("v%0d_mem_addr", i), mem_addr, vecs[i].e_addr);
      end
      chk($sformatf("v%0d_host_rvalid", i), host_rvalid, vecs[i].e_rvalid);
      if (vecs[i].e_rvalid) chk($sformatf("v%0d_host_rdata", i), host_rdata, vecs[i].e_hrd);
      chk($sformatf("v%0d_core_rdata", i), core_rdata, vecs[i].e_crd);
      next_cycle();
    end
    idle();
    @(negedge clk);
    chk("lock_write_readback", core_rdata, 8'hC3);
    next_cycle();

    // Fairness: core requests continuously, host waits for its forced slot
    gnt_at = 0;
    for (int i = 1; i <= 12 && gnt_at == 0; i++) begin
      drive(1'b1, 1'b0, 17'h1000, 8'h00, 1'b1, 1'b0, 17'h1400, 8'h00, 1'b0);
      @(negedge clk);
      if (host_gnt) begin
        gnt_at = i;
        chk("fair_stall_on_gnt", core_stall, 1);
        chk("fair_addr_on_gnt", mem_addr, 17'h1400);
      end else begin
        chk($sformatf("fair_stall_wait%0d", i), core_stall, 0);
      end
      next_cycle();
    end
    chk("fair_gnt_cycle", gnt_at, 9);
    @(negedge clk);
    chk("fair_rvalid", host_rvalid, 1);
    chk("fair_rdata", host_rdata, 8'h33);
    chk("fair_no_b2b_gnt", host_gnt, 0);
    chk("fair_core_resumes", core_stall, 0);
    next_cycle();
    idle();
    next_cycle();

    // Lock load: 16 back-to-back host writes while the core is held off
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b0, 17'h0100, 8'h00, 1'b1, 1'b1, 17'(i), 8'(i), 1'b1);
      @(negedge clk);
      chk($sformatf("lock_gnt%0d", i), host_gnt, 1);
      chk($sformatf("lock_stall%0d", i), core_stall, 1);
      next_cycle();
    end
    drive(1'b1, 1'b0, 17'h0100, 8'h00, 1'b0, 1'b0, 17'h0, 8'h00, 1'b0);
    @(negedge clk);
    chk("lock_drop_stall", core_stall, 1);
    next_cycle();
    @(negedge clk);
    chk("drain_stall", core_stall, 1);
    chk("drain_mem_cs", mem_cs, 0);
    next_cycle();
    drive(1'b1, 1'b0, 17'h0005, 8'h00, 1'b0, 1'b0, 17'h0, 8'h00, 1'b0);
    @(negedge clk);
    chk("resume_stall", core_stall, 0);
    chk("resume_addr", mem_addr, 17'h0005);
    next_cycle();
    idle();
    @(negedge clk);
    chk("resume_rdata", core_rdata, 8'h05);
    next_cycle();
    @(negedge clk);
    chk("resume_rdata_held", core_rdata, 8'h05);
    next_cycle();

    // Host read granted in the cycle the lock drops: data returns in DRAIN
    drive(1'b1, 1'b0, 17'h0100, 8'h00, 1'b0, 1'b0, 17'h0, 8'h00, 1'b1);
    next_cycle();
    drive(1'b1, 1'b0, 17'h0100, 8'h00, 1'b1, 1'b0, 17'h1400, 8'h00, 1'b0);
    @(negedge clk);
    chk("pend_gnt", host_gnt, 1);
    chk("pend_stall", core_stall, 1);
    next_cycle();
    drive(1'b1, 1'b0, 17'h0100, 8'h00, 1'b1, 1'b0, 17'h1400, 8'h00, 1'b0);
    @(negedge clk);
    chk("pend_drain_rvalid", host_rvalid, 1);
    chk("pend_drain_rdata", host_rdata, 8'h33);
    chk("pend_drain_stall", core_stall, 1);
    chk("pend_drain_no_gnt", host_gnt, 0);
    next_cycle();
    idle();
    next_cycle();

    // Reset the cycle after a host read grant: the read is dropped
    drive(1'b0, 1'b0, 17'h0, 8'h00, 1'b1, 1'b0, 17'h1400, 8'h00, 1'b0);
    @(negedge clk);
    chk("rstrd_gnt", host_gnt, 1);
    next_cycle();
    idle();
    rst_n = 1'b0;
    @(negedge clk);
    chk("rstrd_rvalid_in_rst", host_rvalid, 0);
    next_cycle();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rstrd_rvalid_after", host_rvalid, 0);
    chk("rstrd_core_rdata", core_rdata, 0);
`ifdef EJ32_ARB_STAT_EN
    chk("rstrd_stall_cnt", stall_cnt, 0);
`endif
    next_cycle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
